// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets four requesters share one
// UART transmitter. A winner is granted for exactly one frame; the arbiter
// waits for the transmitter's stop-bit pulse (tx_comp) and then inserts a
// one-cycle gap before it arbitrates again.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to enable a tx_comp
// watchdog. When enabled, a frame that never completes is abandoned after
// TIMEOUT_CYCLES cycles in ARB_WAIT, and timeout_err pulses for one cycle.
// When it is not defined, ARB_WAIT waits for tx_comp indefinitely and
// timeout_err is always 0.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 6000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_comp,
  output logic        busy,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  arb_state_t state_r;
  logic [1:0] last_owner_r;

  logic [1:0] pick_s;
  logic       pick_valid_s;
  logic       done_s;
  logic       wd_expire_s;

  // Round-robin pick: first set request starting just after the last owner.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] cand;
    logic [1:0] sel;
    logic       hit;
    sel = 2'd0;
    hit = 1'b0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      sel  = r[cand] ? cand : sel;
      hit  = r[cand] ? 1'b1 : hit;
    end
    return {hit, sel};
  endfunction

  // Arbitration choice for the current cycle's request vector.
  always_comb begin
    {pick_valid_s, pick_s} = rr_pick(req, last_owner_r);
  end

  // A tx_comp seen during the tx_start cycle belongs to no frame of ours
  // (the transmitter has not yet launched), so it is discarded.
  assign done_s = tx_comp & ~tx_start;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_r;

  // Watchdog fires on the last allowed ARB_WAIT cycle unless tx_comp wins.
  assign wd_expire_s = (state_r == ARB_WAIT) && !done_s &&
                       (wd_cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: zero outside ARB_WAIT, counts every ARB_WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire_s;
      if (state_r == ARB_WAIT) begin
        wd_cnt_r <= wd_cnt_r + 16'd1;
      end else begin
        wd_cnt_r <= 16'd0;
      end
    end
  end
`else
  assign wd_expire_s = 1'b0;
  // The parameter is referenced so both builds share one interface; the
  // result is constant 0.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

  // Arbiter FSM with registered grant/start/data/busy/owner outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB_IDLE;
      gnt          <= 4'b0000;
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      busy         <= 1'b0;
      owner        <= 2'd0;
      last_owner_r <= 2'd3;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_valid_s) begin
            gnt      <= 4'b0001 << pick_s;
            tx_start <= 1'b1;
            tx_data  <= req_data[{pick_s, 3'b000} +: 8];
            owner    <= pick_s;
            busy     <= 1'b1;
            state_r  <= ARB_WAIT;
          end else begin
            gnt      <= 4'b0000;
            tx_start <= 1'b0;
          end
        end
        ARB_WAIT: begin
          gnt      <= 4'b0000;
          tx_start <= 1'b0;
          if (done_s || wd_expire_s) begin
            busy         <= 1'b0;
            last_owner_r <= owner;
            state_r      <= ARB_GAP;
          end else begin
            state_r      <= ARB_WAIT;
          end
        end
        ARB_GAP: begin
          gnt      <= 4'b0000;
          tx_start <= 1'b0;
          state_r  <= ARB_IDLE;
        end
        default: begin
          gnt      <= 4'b0000;
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state_r  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_comp;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_comp(tx_comp),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a frame is either in flight or not, plus a cool-down
  // count of cycles during which new requests are not looked at.
  bit         m_in_flight = 1'b0;
  int         m_cool = 0;
  int         m_age = 0;
  int         m_last = 3;
  logic [3:0] e_gnt = 4'b0000;
  logic       e_start = 1'b0;
  logic [7:0] e_data = 8'h00;
  logic [1:0] e_owner = 2'd0;
  logic       e_terr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic end_frame();
    m_in_flight = 1'b0;
    m_last      = int'(e_owner);
    m_cool      = 1;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic c);
    logic prev_start;
    int   idx;
    prev_start = e_start;
    if (r) begin
      m_in_flight = 1'b0; m_cool = 0; m_age = 0; m_last = 3;
      e_gnt = 4'b0000; e_start = 1'b0; e_data = 8'h00; e_owner = 2'd0; e_terr = 1'b0;
    end else begin
      e_gnt = 4'b0000; e_start = 1'b0; e_terr = 1'b0;
      if (m_in_flight) begin
        if (c && !prev_start) begin
          end_frame();
`ifdef UART_ARB_TIMEOUT_EN
        end else if (m_age == T - 1) begin
          e_terr = 1'b1;
          end_frame();
`endif
        end else begin
          m_age++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (rq != 4'b0000) begin
        idx = -1;
        for (int k = 1; k <= 4; k++) begin
          if (idx < 0 && rq[(m_last + k) % 4]) idx = (m_last + k) % 4;
        end
        e_gnt       = 4'b0001 << idx;
        e_start     = 1'b1;
        e_data      = d[8*idx +: 8];
        e_owner     = 2'(idx);
        m_in_flight = 1'b1;
        m_age       = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic c, input string tag);
    rst = r; req = rq; req_data = d; tx_comp = c;
    @(posedge clk);
    model_edge(r, rq, d, c);
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".tx_start"}, 32'(tx_start), 32'(e_start));
    check({tag, ".tx_data"}, 32'(tx_data), 32'(e_data));
    check({tag, ".busy"}, 32'(busy), 32'(m_in_flight));
    check({tag, ".owner"}, 32'(owner), 32'(e_owner));
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'(e_terr));
  endtask

  localparam logic [31:0] D = 32'h44_33_22_11;
  int rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = 4'hF; req_data = D; tx_comp = 1'b0;

    // Reset with all requests pending.
    cyc(1'b1, 4'hF, D, 1'b0, "reset");
    cyc(1'b1, 4'hF, D, 1'b0, "reset");
    check("reset.gnt_zero", 32'(gnt), 32'h0);
    check("reset.tx_data_zero", 32'(tx_data), 32'h0);
    cyc(1'b0, 4'hF, D, 1'b0, "first_grant");
    check("first_grant.gnt", 32'(gnt), 32'h1);
    repeat (4) cyc(1'b0, 4'h0, D, 1'b0, "first_wait");
    cyc(1'b0, 4'h0, D, 1'b1, "first_comp");
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "first_gap");

    // Single requester, held across the frame: regrant 3 cycles after tx_comp.
    cyc(1'b1, 4'h0, D, 1'b0, "single_rst");
    cyc(1'b0, 4'b0100, 32'h00A5_0000, 1'b0, "single_grant");
    check("single.gnt", 32'(gnt), 32'h4);
    check("single.tx_data", 32'(tx_data), 32'hA5);
    check("single.owner", 32'(owner), 32'd2);
    repeat (9) cyc(1'b0, 4'b0100, 32'h00A5_0000, 1'b0, "single_wait");
    cyc(1'b0, 4'b0100, 32'h00A5_0000, 1'b1, "single_comp");
    check("single.busy_drop", 32'(busy), 32'd0);
    cyc(1'b0, 4'b0100, 32'h005A_0000, 1'b0, "single_gap");
    cyc(1'b0, 4'b0100, 32'h005A_0000, 1'b0, "single_regrant");
    check("single.regrant_gnt", 32'(gnt), 32'h4);
    check("single.regrant_data", 32'(tx_data), 32'h5A);
    repeat (3) cyc(1'b0, 4'h0, D, 1'b0, "single_wait2");
    cyc(1'b0, 4'h0, D, 1'b1, "single_comp2");
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "single_gap2");

    // Round robin with all requesters held.
    cyc(1'b1, 4'hF, D, 1'b0, "rr_rst");
    for (int g = 0; g < 5; g++) begin
      cyc(1'b0, 4'hF, D, 1'b0, "rr_grant");
      check("rr.order", 32'(gnt), 32'(4'b0001 << rr_order[g]));
      repeat (4) cyc(1'b0, 4'hF, D, 1'b0, "rr_wait");
      cyc(1'b0, 4'hF, D, 1'b1, "rr_comp");
      cyc(1'b0, 4'hF, D, 1'b0, "rr_gap");
    end
    cyc(1'b0, 4'h0, D, 1'b0, "rr_tail");
    repeat (3) cyc(1'b0, 4'h0, D, 1'b0, "rr_tail_wait");
    cyc(1'b0, 4'h0, D, 1'b1, "rr_tail_comp");
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "rr_tail_gap");

    // Owner 3, then req[0] withdrawn before it is ever sampled.
    cyc(1'b0, 4'b1000, D, 1'b0, "wd_own3");
    check("withdraw.owner3", 32'(owner), 32'd3);
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "wd_wait");
    cyc(1'b0, 4'b0011, D, 1'b1, "wd_comp");
    cyc(1'b0, 4'b0011, D, 1'b0, "wd_gap");
    cyc(1'b0, 4'b0010, D, 1'b0, "wd_grant");
    check("withdraw.gnt", 32'(gnt), 32'h2);
    cyc(1'b0, 4'h0, D, 1'b1, "wd_comp2_ignored");
    cyc(1'b0, 4'h0, D, 1'b1, "wd_comp2");
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "wd_gap2");
    // Wrap: owner 3, req 0011 -> requester 0.
    cyc(1'b0, 4'b1000, D, 1'b0, "wrap_own3");
    cyc(1'b0, 4'h0, D, 1'b0, "wrap_wait");
    cyc(1'b0, 4'h0, D, 1'b1, "wrap_comp");
    cyc(1'b0, 4'h0, D, 1'b0, "wrap_gap");
    cyc(1'b0, 4'b0011, D, 1'b0, "wrap_grant");
    check("wrap.gnt", 32'(gnt), 32'h1);
    cyc(1'b0, 4'h0, D, 1'b0, "wrap_wait2");
    cyc(1'b0, 4'h0, D, 1'b1, "wrap_comp2");
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "wrap_gap2");

    // Spurious tx_comp in idle, then tx_comp coincident with tx_start.
    repeat (3) cyc(1'b0, 4'h0, D, 1'b1, "spur_idle");
    check("spur.idle_busy", 32'(busy), 32'd0);
    cyc(1'b0, 4'b0001, D, 1'b0, "spur_grant");
    cyc(1'b0, 4'h0, D, 1'b1, "spur_coincident");
    check("spur.busy_held", 32'(busy), 32'd1);
    repeat (3) cyc(1'b0, 4'h0, D, 1'b0, "spur_wait");
    check("spur.busy_still", 32'(busy), 32'd1);
    cyc(1'b0, 4'h0, D, 1'b1, "spur_comp");
    check("spur.busy_drop", 32'(busy), 32'd0);
    repeat (2) cyc(1'b0, 4'h0, D, 1'b0, "spur_gap");

    // Watchdog: no tx_comp for a long time.
    cyc(1'b0, 4'b0010, D, 1'b0, "to_grant");
    for (int i = 1; i <= 1000; i++) begin
      cyc(1'b0, 4'h0, D, 1'b0, "to_wait");
`ifdef UART_ARB_TIMEOUT_EN
      if (i == T) begin
        check("timeout.err", 32'(timeout_err), 32'd1);
        check("timeout.busy", 32'(busy), 32'd0);
      end
`else
      if (i == 1000) check("no_timeout.busy", 32'(busy), 32'd1);
`endif
    end

    // Random traffic.
    cyc(1'b1, 4'h0, D, 1'b0, "rand_rst");
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
          32'($urandom),
          1'($urandom_range(0, 7) == 0),
          "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
